// File: rtl/proc8_pkg.sv
// Shared widths and ALU opcode encodings for the proc8 execution/storage core.
package proc8_pkg;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_INV  = 3'b101;
    localparam logic [2:0] ALU_PASS = 3'b110;
    localparam logic [2:0] ALU_SHL  = 3'b111;

endpackage

// File: rtl/proc8_alu_core.sv
// Combinational 8-bit ALU with carry/borrow/shift-out and zero flags.
module proc8_alu_core
    import proc8_pkg::*;
(
    input  logic [2:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] alu_out,
    output logic              cy,
    output logic              zero
);

    logic [DATA_W:0]     add_w;
    logic [DATA_W:0]     sub_w;
    logic [2*DATA_W-1:0] shl_w;
    logic                shl_in_range;

    assign add_w = {1'b0, a} + {1'b0, b};
    // Bit 8 of the 9-bit difference is the borrow (set exactly when a < b).
    assign sub_w = {1'b0, a} - {1'b0, b};

    // Shifting a zero-extended copy leaves the last bit shifted out in bit 8;
    // amounts above 8 push everything out, so result and flag are both 0.
    assign shl_in_range = (b <= DATA_W'(DATA_W));
    assign shl_w        = shl_in_range ? ({{DATA_W{1'b0}}, a} << b[3:0])
                                       : '0;

    always_comb begin
        alu_out = '0;
        cy      = 1'b0;
        case (opcode)
            ALU_ADD:  {cy, alu_out} = add_w;
            ALU_SUB:  {cy, alu_out} = sub_w;
            ALU_AND:  alu_out = a & b;
            ALU_OR:   alu_out = a | b;
            ALU_XOR:  alu_out = a ^ b;
            ALU_INV:  alu_out = ~a;
            ALU_PASS: alu_out = b;
            ALU_SHL: begin
                alu_out = shl_w[DATA_W-1:0];
                cy      = shl_w[DATA_W];
            end
            default: begin
                alu_out = '0;
                cy      = 1'b0;
            end
        endcase
    end

    assign zero = (alu_out == '0);

endmodule

// File: rtl/proc8_datapath_core.sv
// proc8 execution/storage core: ALU, 256x16 instruction store with registered
// fetch, and 256x8 data memory with a registered 16-bit read bus.
module proc8_datapath_core
    import proc8_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         opcode,
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    output logic [DATA_W-1:0]  alu_out,
    output logic               cy,
    output logic               zero,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               en,
    output logic [INSTR_W-1:0] ir_data,
    input  logic               imem_we,
    input  logic [ADDR_W-1:0]  imem_waddr,
    input  logic [INSTR_W-1:0] imem_wdata,
    input  logic [ADDR_W-1:0]  maddr,
    input  logic               mrd,
    input  logic               mwr,
    input  logic [DATA_W-1:0]  mwr_data,
    output logic [INSTR_W-1:0] m_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [INSTR_W-1:0] imem_q [DEPTH];
    logic [DATA_W-1:0]  dmem_q [DEPTH];

    logic [INSTR_W-1:0] ir_data_q, ir_data_d;
    logic [INSTR_W-1:0] m_data_q,  m_data_d;

    proc8_alu_core u_alu (
        .opcode  (opcode),
        .a       (a),
        .b       (b),
        .alu_out (alu_out),
        .cy      (cy),
        .zero    (zero)
    );

    // Arrays are never cleared; writes are simply blocked while reset is high.
    always_ff @(posedge clk) begin
        if (!rst && imem_we) begin
            imem_q[imem_waddr] <= imem_wdata;
        end
        if (!rst && mwr) begin
            dmem_q[maddr] <= mwr_data;
        end
    end

    // Reads sample the arrays before this edge's writes land (read-before-write).
    always_comb begin
        ir_data_d = ir_data_q;
        m_data_d  = m_data_q;
        if (en) begin
            ir_data_d = imem_q[pc];
        end
        if (mrd) begin
            m_data_d = {{(INSTR_W-DATA_W){1'b0}}, dmem_q[maddr]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_data_q <= '0;
            m_data_q  <= '0;
        end else begin
            ir_data_q <= ir_data_d;
            m_data_q  <= m_data_d;
        end
    end

    assign ir_data = ir_data_q;
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_proc8_datapath_core.sv
// Self-checking bench for proc8_datapath_core: directed cases plus randomized
// traffic against an arithmetic ALU model and array-based memory models.
module tb_proc8_datapath_core;
    import proc8_pkg::*;

    logic               clk;
    logic               rst;
    logic [2:0]         opcode;
    logic [DATA_W-1:0]  a, b;
    logic [DATA_W-1:0]  alu_out;
    logic               cy, zero;
    logic [ADDR_W-1:0]  pc;
    logic               en;
    logic [INSTR_W-1:0] ir_data;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_waddr;
    logic [INSTR_W-1:0] imem_wdata;
    logic [ADDR_W-1:0]  maddr;
    logic               mrd, mwr;
    logic [DATA_W-1:0]  mwr_data;
    logic [INSTR_W-1:0] m_data;

    int checks;
    int fails;

    logic [INSTR_W-1:0] model_imem [256];
    logic [DATA_W-1:0]  model_dmem [256];
    logic [INSTR_W-1:0] exp_ir;
    logic [INSTR_W-1:0] exp_m;

    proc8_datapath_core dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .a          (a),
        .b          (b),
        .alu_out    (alu_out),
        .cy         (cy),
        .zero       (zero),
        .pc         (pc),
        .en         (en),
        .ir_data    (ir_data),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .maddr      (maddr),
        .mrd        (mrd),
        .mwr        (mwr),
        .mwr_data   (mwr_data),
        .m_data     (m_data)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU reference from plain integer arithmetic; returns {cy, out}
    function automatic logic [8:0] alu_model(input logic [2:0] op, input int av, input int bv);
        int r;
        int c;
        r = 0;
        c = 0;
        case (op)
            3'd0: begin r = (av + bv) % 256; c = ((av + bv) >= 256) ? 1 : 0; end
            3'd1: begin r = (av - bv + 256) % 256; c = (av < bv) ? 1 : 0; end
            3'd2: r = av & bv;
            3'd3: r = av | bv;
            3'd4: r = av ^ bv;
            3'd5: r = 255 - av;
            3'd6: r = bv;
            default: begin
                if (bv >= 8) r = 0;
                else r = (av * (1 << bv)) % 256;
                if (bv >= 1 && bv <= 8) c = (av >> (8 - bv)) & 1;
            end
        endcase
        return {c[0], r[7:0]};
    endfunction

    // driver tasks
    task automatic idle_inputs();
        en = 1'b0; pc = '0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        mrd = 1'b0; mwr = 1'b0; maddr = '0; mwr_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_imem(input logic [7:0] ad, input logic [15:0] d);
        imem_we = 1'b1; imem_waddr = ad; imem_wdata = d;
        tick();
        imem_we = 1'b0;
        model_imem[ad] = d;
    endtask

    task automatic write_dmem(input logic [7:0] ad, input logic [7:0] d);
        mwr = 1'b1; maddr = ad; mwr_data = d;
        tick();
        mwr = 1'b0;
        model_dmem[ad] = d;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (ir_data !== 16'h0000) begin
            fails++; $display("FAIL reset_ir: got %h expected 0000", ir_data);
        end
        checks++;
        if (m_data !== 16'h0000) begin
            fails++; $display("FAIL reset_m: got %h expected 0000", m_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu_directed();
        logic [2:0] t_op [14] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4,
                                  3'd5, 3'd7, 3'd7, 3'd7, 3'd7, 3'd6, 3'd7};
        logic [7:0] t_a  [14] = '{8'd200, 8'd0, 8'd5, 8'd3, 8'hF0, 8'hF0, 8'hF0,
                                  8'hFF, 8'h81, 8'h81, 8'hFF, 8'hFF, 8'h12, 8'h40};
        logic [7:0] t_b  [14] = '{8'd100, 8'd0, 8'd5, 8'd5, 8'h3C, 8'h3C, 8'h3C,
                                  8'h77, 8'd1, 8'd8, 8'd9, 8'd0, 8'h00, 8'd2};
        logic [7:0] t_o  [14] = '{8'd44, 8'd0, 8'd0, 8'd254, 8'h30, 8'hFC, 8'hCC,
                                  8'h00, 8'h02, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
        logic       t_c  [14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 14; i++) begin
            opcode = t_op[i]; a = t_a[i]; b = t_b[i];
            // the ALU ignores reset; exercise that on one entry
            rst = (i == 3);
            #1;
            checks++;
            if (alu_out !== t_o[i] || cy !== t_c[i] || zero !== (t_o[i] == 8'h00)) begin
                fails++;
                $display("FAIL alu_dir[%0d]: op=%0d a=%h b=%h got out=%h cy=%b z=%b expected out=%h cy=%b z=%b",
                         i, t_op[i], t_a[i], t_b[i], alu_out, cy, zero, t_o[i], t_c[i], t_o[i] == 8'h00);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_alu_random();
        logic [8:0] exp;
        for (int i = 0; i < 400; i++) begin
            opcode = 3'($urandom_range(0, 7));
            a = 8'($urandom_range(0, 255));
            b = (opcode == ALU_SHL && $urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 10))
                                                                   : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) a = b;
            #1;
            exp = alu_model(opcode, int'(a), int'(b));
            checks++;
            if (alu_out !== exp[7:0] || cy !== exp[8] || zero !== (exp[7:0] == 8'h00)) begin
                fails++;
                $display("FAIL alu_rand: op=%0d a=%h b=%h got out=%h cy=%b z=%b expected out=%h cy=%b",
                         opcode, a, b, alu_out, cy, zero, exp[7:0], exp[8]);
            end
        end
    endtask

    task automatic test_fetch();
        idle_inputs();
        prog_imem(8'd3, 16'h4105);
        prog_imem(8'd4, 16'h1234);
        pc = 8'd3; en = 1'b1;
        tick();
        checks++;
        if (ir_data !== 16'h4105) begin
            fails++; $display("FAIL fetch: got %h expected 4105", ir_data);
        end
        pc = 8'd4; en = 1'b0;
        tick();
        checks++;
        if (ir_data !== 16'h4105) begin
            fails++; $display("FAIL fetch_hold: got %h expected 4105", ir_data);
        end
        // same-address write and fetch returns the old word
        prog_imem(8'd7, 16'hAAAA);
        imem_we = 1'b1; imem_waddr = 8'd7; imem_wdata = 16'hBBBB;
        pc = 8'd7; en = 1'b1;
        tick();
        imem_we = 1'b0;
        model_imem[7] = 16'hBBBB;
        checks++;
        if (ir_data !== 16'hAAAA) begin
            fails++; $display("FAIL fetch_rbw: got %h expected AAAA", ir_data);
        end
        tick();
        checks++;
        if (ir_data !== 16'hBBBB) begin
            fails++; $display("FAIL fetch_after_wr: got %h expected BBBB", ir_data);
        end
        en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ir_data !== 16'h0000) begin
            fails++; $display("FAIL fetch_rst: got %h expected 0000", ir_data);
        end
    endtask

    task automatic test_dmem();
        idle_inputs();
        write_dmem(8'h10, 8'hA5);
        mrd = 1'b1; maddr = 8'h10;
        tick();
        checks++;
        if (m_data !== 16'h00A5) begin
            fails++; $display("FAIL dmem_read: got %h expected 00A5", m_data);
        end
        mrd = 1'b1; mwr = 1'b1; maddr = 8'h10; mwr_data = 8'h5A;
        tick();
        model_dmem[8'h10] = 8'h5A;
        checks++;
        if (m_data !== 16'h00A5) begin
            fails++; $display("FAIL dmem_rbw: got %h expected 00A5", m_data);
        end
        mwr = 1'b0;
        tick();
        checks++;
        if (m_data !== 16'h005A) begin
            fails++; $display("FAIL dmem_after_wr: got %h expected 005A", m_data);
        end
        mrd = 1'b0; maddr = 8'h11;
        tick();
        checks++;
        if (m_data !== 16'h005A) begin
            fails++; $display("FAIL dmem_hold: got %h expected 005A", m_data);
        end
    endtask

    task automatic test_reset_writes();
        idle_inputs();
        write_dmem(8'h20, 8'h11);
        prog_imem(8'd5, 16'h7777);
        rst = 1'b1;
        mwr = 1'b1; maddr = 8'h20; mwr_data = 8'h99;
        imem_we = 1'b1; imem_waddr = 8'd5; imem_wdata = 16'hDEAD;
        tick();
        rst = 1'b0;
        idle_inputs();
        checks++;
        if (m_data !== 16'h0000 || ir_data !== 16'h0000) begin
            fails++; $display("FAIL rst_outputs: got m=%h ir=%h expected 0000 0000", m_data, ir_data);
        end
        // first edge after reset falls behaves normally
        mrd = 1'b1; maddr = 8'h20; en = 1'b1; pc = 8'd5;
        tick();
        checks++;
        if (m_data !== 16'h0011) begin
            fails++; $display("FAIL rst_dmem_write_ignored: got %h expected 0011", m_data);
        end
        checks++;
        if (ir_data !== 16'h7777) begin
            fails++; $display("FAIL rst_imem_write_ignored: got %h expected 7777", ir_data);
        end
        idle_inputs();
    endtask

    task automatic test_random_mem();
        idle_inputs();
        for (int i = 0; i < 256; i++) begin
            imem_we = 1'b1; imem_waddr = 8'(i); imem_wdata = 16'($urandom);
            mwr = 1'b1; maddr = 8'(i); mwr_data = 8'($urandom);
            tick();
            model_imem[i] = imem_wdata;
            model_dmem[i] = mwr_data;
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        exp_ir = '0;
        exp_m  = '0;
        for (int i = 0; i < 1500; i++) begin
            rst        = ($urandom_range(0, 29) == 0);
            en         = 1'($urandom);
            pc         = 8'($urandom);
            imem_we    = 1'($urandom);
            imem_waddr = ($urandom_range(0, 3) == 0) ? pc : 8'($urandom);
            imem_wdata = 16'($urandom);
            mrd        = 1'($urandom);
            mwr        = 1'($urandom);
            maddr      = 8'($urandom_range(0, 15));
            mwr_data   = 8'($urandom);
            if (rst) begin
                exp_ir = '0;
                exp_m  = '0;
            end else begin
                if (en)  exp_ir = model_imem[pc];
                if (mrd) exp_m  = {8'h00, model_dmem[maddr]};
                if (imem_we) model_imem[imem_waddr] = imem_wdata;
                if (mwr)     model_dmem[maddr] = mwr_data;
            end
            tick();
            checks++;
            if (ir_data !== exp_ir || m_data !== exp_m) begin
                fails++;
                $display("FAIL rand_mem[%0d]: got ir=%h m=%h expected ir=%h m=%h",
                         i, ir_data, m_data, exp_ir, exp_m);
            end
        end
        idle_inputs();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst = 1'b1;
        opcode = '0; a = '0; b = '0;
        idle_inputs();
        test_reset();
        test_alu_directed();
        test_alu_random();
        test_fetch();
        test_dmem();
        test_reset_writes();
        test_random_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
